mpaddsub_limb: RTL and testbench
================================

# mpaddsub_limb

Parametrised multi-precision adder/subtractor that processes operands one LIMB-bit slice per cycle, with a ripple carry/borrow register between slices. Generalises the fixed 1027-bit add/sub unit: arbitrary WIDTH and LIMB, plus constant-time modular add and modular subtract modes. It sits in the datapath beside the Montgomery multiplier and serves final reductions and field add/sub under a start/done handshake.

## Interface
- WIDTH, 1027, operand width in bits
- LIMB, 64, bits processed per cycle; NLIMB = ceil(WIDTH/LIMB)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- mode  input  2  00 add, 01 sub, 10 modadd, 11 modsub; latched with start
- in_a  input  WIDTH  operand A; latched with start
- in_b  input  WIDTH  operand B; latched with start
- in_m  input  WIDTH  modulus; latched with start; ignored in modes 00/01
- result  output  WIDTH+1  result; valid while done=1 and held until the next accepted start
- done  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after start is accepted until done

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: start=1 latches mode, in_a, in_b, and in_m, zero-padded to NLIMB*LIMB bits. Sets the limb counter to 0 and goes to PASS1. Carry init is 0 for add and 1 for sub; B is inverted for sub.
- PASS1: each cycle computes limb i of t = A±B and updates the carry register; the counter increments.
  - At i = NLIMB-1, go to DONE (modes 00/01) or PASS2 (modes 10/11).
- PASS2 always runs NLIMB cycles, independent of data (constant time).
  - modadd: u = t − M; result = u if there is no borrow out of WIDTH+1 bits, else t.
  - modsub: u = t + M; result = u if PASS1 borrowed (t negative), else t.
- DONE: done=1 for one cycle, then IDLE. The result register stays stable until the next accepted start.
- Width rules:
  - add: result = A+B, with the carry-out in bit WIDTH.
  - sub: result = (A−B) mod 2^(WIDTH+1); two's complement, so the MSB=1 means negative.
  - modular modes require A,B < M. Then result < M and bit WIDTH = 0. Behaviour is unspecified otherwise.
- start while busy or in DONE is ignored; no queueing.
- Padding bits above WIDTH in the top limb never affect result bits.

## Timing
- Reset values: state IDLE, result 0, done 0, busy 0, counter 0, carry 0.
- Latency is counted from the rising edge that samples start (edge 0):
  - modes 00/01: done at edge NLIMB+1.
  - modes 10/11: done at edge 2*NLIMB+1.
- busy is high on edges 1..done−1.
- A back-to-back start may be asserted in the cycle done=1 is sampled low again. Minimum issue interval is NLIMB+2 or 2*NLIMB+2 cycles.
- Reset mid-operation returns the block immediately to IDLE with all outputs zero. No done is produced for the aborted op.
- Throughput is independent of operand values in every mode.

## Test plan
- WIDTH=1027, LIMB=64 (NLIMB=17): add 0xc + 0xd -> result 0x19, done at edge 18, busy high on edges 1..17.
- Sub 2−2 -> 0.
- Sub 1−2 -> result = 2^1028−1 (all ones), MSB=1.
- add (2^1027−1)+1 -> result = 1<<1027. This checks carry ripple through all 17 limbs.
- Modadd, m=0x17: a=0x10, b=0xc -> 0x5, done at edge 35.
- Modsub, m=0x17: a=3, b=5 -> 0x15. A second case a=5, b=3 -> 0x2 must also have done at edge 35.
- Random 1027-bit vectors against a golden model in all four modes.
- Parameter sweep WIDTH=100, LIMB=32 (NLIMB=4, padded top limb): a=2^100−1, b=1, add -> 1<<100, done at edge 5.
- Robustness:
  - start pulsed during PASS1 is ignored, and the result is unchanged.
  - reset asserted at edge 8 of a modadd drives result=0, done=0, busy=0 immediately.
  - a new start after reset completes normally.

Source files
------------

// File: rtl/mpaddsub_limb_if.sv
// Request/response bundle for mpaddsub_limb: operands and mode go in with a start
// pulse, and the result comes back qualified by a one-cycle done pulse.
interface mpaddsub_limb_if #(
  parameter int WIDTH = 1027
);
  // Handshake: start is a one-cycle request, honoured only while the block is idle.
  // It is not back-pressured; a start raised while busy or done is dropped.
  // done pulses for exactly one cycle, and result is valid from that cycle until
  // the next completion.
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH:0]   result;
  logic             done;
  logic             busy;

  modport master (
    output start, mode, in_a, in_b, in_m,
    input  result, done, busy
  );

  modport slave (
    input  start, mode, in_a, in_b, in_m,
    output result, done, busy
  );
endinterface

// File: rtl/mpaddsub_limb.sv
// Limb-serial multi-precision add/sub with constant-time modular add/sub.
// It uses one LIMB-bit adder, which pass 1 and the correction pass 2 share.
module mpaddsub_limb #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  mpaddsub_limb_if.slave        bus_if,
  output logic [1:0]            state_o
);
  localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int PW    = NLIMB * LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           ext_q, ext_d;
  logic [1:0]     mode_q, mode_d;
  logic [PW-1:0]  x_q, x_d;
  logic [PW-1:0]  y_q, y_d;
  logic [PW-1:0]  m_q, m_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [WIDTH:0] result_q, result_d;

  logic [PW-1:0]  a_pad, b_pad, m_pad;
  logic [LIMB:0]  limb_sum;
  logic [PW-1:0]  sum_ext;
  logic [PW-1:0]  acc_shift;
  logic [PW-1:0]  x_rot;
  logic           last_limb;
  logic           ext_new;
  logic [PW:0]    full_t;
  logic           take_u;
  logic [PW-1:0]  pick;

  assign a_pad = PW'(bus_if.in_a);
  assign b_pad = PW'(bus_if.in_b);
  assign m_pad = PW'(bus_if.in_m);

  // The sum limb enters at the top of acc, so after NLIMB shifts acc holds the whole word.
  assign limb_sum  = {1'b0, x_q[LIMB-1:0]} + {1'b0, y_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};
  assign sum_ext   = PW'(limb_sum[LIMB-1:0]);
  assign acc_shift = (acc_q >> LIMB) | (sum_ext << (PW - LIMB));
  // In pass 2, x rotates so that t is back in place after NLIMB steps.
  assign x_rot     = (x_q >> LIMB) | (x_q << (PW - LIMB));
  assign last_limb = (cnt_q == CW'(NLIMB - 1));

  // Bit PW of the pass-1 value: the carry for add, the sign (no carry) for sub.
  assign ext_new = limb_sum[LIMB] ^ mode_q[0];
  assign full_t  = {ext_new, acc_shift};

  // modadd keeps t-M unless t<M; modsub keeps t+M only when A-B went negative.
  assign take_u = mode_q[0] ? ext_q : (ext_q | limb_sum[LIMB]);
  assign pick   = take_u ? acc_shift : x_rot;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    ext_d    = ext_q;
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    m_d      = m_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          mode_d  = bus_if.mode;
          x_d     = a_pad;
          y_d     = bus_if.mode[0] ? ~b_pad : b_pad;
          m_d     = m_pad;
          carry_d = bus_if.mode[0];
          ext_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = PASS1;
        end
      end
      PASS1: begin
        x_d     = x_q >> LIMB;
        y_d     = y_q >> LIMB;
        acc_d   = acc_shift;
        carry_d = limb_sum[LIMB];
        cnt_d   = cnt_q + CW'(1);
        if (last_limb) begin
          ext_d = ext_new;
          cnt_d = '0;
          if (mode_q[1]) begin
            x_d     = acc_shift;
            y_d     = mode_q[0] ? m_q : ~m_q;
            carry_d = ~mode_q[0];
            state_d = PASS2;
          end else begin
            result_d = (WIDTH + 1)'(full_t);
            state_d  = DONE;
          end
        end
      end
      PASS2: begin
        x_d     = x_rot;
        y_d     = y_q >> LIMB;
        acc_d   = acc_shift;
        carry_d = limb_sum[LIMB];
        cnt_d   = cnt_q + CW'(1);
        if (last_limb) begin
          result_d = {1'b0, WIDTH'(pick)};
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ext_q    <= 1'b0;
      mode_q   <= 2'b00;
      x_q      <= '0;
      y_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ext_q    <= ext_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      y_q      <= y_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus_if.result = result_q;
  assign bus_if.done   = (state_q == DONE);
  assign bus_if.busy   = (state_q == PASS1) || (state_q == PASS2);
  assign state_o       = state_q;
endmodule

// File: tb/tb_mpaddsub_limb.sv
// Bench for mpaddsub_limb: directed and random operations checked against an
// expected-result queue, plus latency, busy, abort and a WIDTH=100 instance.
module tb_mpaddsub_limb;
  localparam int W   = 1027;
  localparam int L   = 64;
  localparam int NL  = 17;
  localparam int W2  = 100;
  localparam int L2  = 32;
  localparam int NL2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mpaddsub_limb_if #(.WIDTH(W))  bus1 ();
  mpaddsub_limb_if #(.WIDTH(W2)) bus2 ();
  logic [1:0] st1, st2;

  mpaddsub_limb #(.WIDTH(W), .LIMB(L)) dut (
    .clk    (clk),
    .reset  (rst),
    .bus_if (bus1),
    .state_o(st1)
  );

  mpaddsub_limb #(.WIDTH(W2), .LIMB(L2)) dut2 (
    .clk    (clk),
    .reset  (rst),
    .bus_if (bus2),
    .state_o(st2)
  );

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] last_res;
  int c0;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed top=%h low=%h expected top=%h low=%h",
             tag, obs[W:W-3], obs[127:0], exp[W:W-3], exp[127:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [1:0] md, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] s;
    s = '0;
    case (md)
      2'b00: s = {2'b00, a} + {2'b00, b};
      2'b01: s = {2'b00, a} - {2'b00, b};
      2'b10: begin
        s = {2'b00, a} + {2'b00, b};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
      end
      default: begin
        if (a >= b) s = {2'b00, a} - {2'b00, b};
        else        s = {2'b00, a} + {2'b00, m} - {2'b00, b};
      end
    endcase
    return s[W:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom());
    return r;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus1.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end else begin
        chk("result", bus1.result, exp_q.pop_front());
      end
    end
  end

  task automatic start_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic [W:0] exp, input bit push);
    @(negedge clk);
    bus1.mode  = md;
    bus1.in_a  = a;
    bus1.in_b  = b;
    bus1.in_m  = m;
    bus1.start = 1'b1;
    c0 = cyc;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  // n is the index of the edge that will sample the values seen at this negedge.
  task automatic wait_done(input int lat);
    int n;
    bit seen;
    seen = 1'b0;
    n = cyc - c0;
    while (!seen && n <= lat + 8) begin
      if (bus1.done) begin
        seen = 1'b1;
        chk_i("latency", n, lat);
        chk_i("busy_at_done", int'(bus1.busy), 0);
      end else begin
        chk_i("busy", int'(bus1.busy), (n >= 1 && n < lat) ? 1 : 0);
        @(negedge clk);
        n = cyc - c0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL timeout observed=no_done expected=done_at_edge_%0d", lat);
    end
  endtask

  task automatic run(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] m, input logic [W:0] exp);
    start_op(md, a, b, m, exp, 1'b1);
    wait_done(md[1] ? 2 * NL + 1 : NL + 1);
    last_res = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb, rm;
    logic [W:0]   one_top;
    logic [W2:0]  exp2;
    int           n2;
    bit           seen2;

    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.in_a = '0; bus1.in_b = '0; bus1.in_m = '0;
    bus2.start = 1'b0; bus2.mode = 2'b00; bus2.in_a = '0; bus2.in_b = '0; bus2.in_m = '0;
    one_top  = '0;
    one_top[W] = 1'b1;
    last_res = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_result", bus1.result, '0);
    chk_i("rst_done", int'(bus1.done), 0);
    chk_i("rst_busy", int'(bus1.busy), 0);
    chk_i("rst_state", int'(st1), 0);
    rst = 1'b0;

    run(2'b00, W'('hc), W'('hd), '0, (W + 1)'('h19));
    run(2'b01, W'(2), W'(2), '0, '0);
    run(2'b01, W'(1), W'(2), '0, '1);
    run(2'b00, '1, W'(1), '0, one_top);
    run(2'b10, W'('h10), W'('hc), W'('h17), (W + 1)'('h5));
    run(2'b11, W'(3), W'(5), W'('h17), (W + 1)'('h15));
    run(2'b11, W'(5), W'(3), W'('h17), (W + 1)'('h2));
    run(2'b10, W'('h16), W'('h16), W'('h17), (W + 1)'('h15));

    for (int md = 0; md < 4; md++) begin
      for (int k = 0; k < 4; k++) begin
        rm = rand_w();
        rm[W-1] = 1'b1;
        ra = rand_w();
        rb = rand_w();
        if (md >= 2) begin
          ra = ra % rm;
          rb = rb % rm;
        end
        run(2'(md), ra, rb, rm, model(2'(md), ra, rb, rm));
      end
    end

    // A start raised mid-pass must neither disturb this op nor queue a second one.
    start_op(2'b00, W'(5), W'(6), '0, (W + 1)'(11), 1'b1);
    @(negedge clk);
    chk("result_held", bus1.result, last_res);
    bus1.mode = 2'b01;
    bus1.in_a = W'('hff);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_done(NL + 1);
    repeat (2 * NL + 4) @(negedge clk);
    chk_i("idle_after_ignored_start", int'(st1), 0);

    // Abort a modadd with reset before edge 8.
    start_op(2'b10, W'('h10), W'('hc), W'('h17), '0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_result", bus1.result, '0);
    chk_i("abort_done", int'(bus1.done), 0);
    chk_i("abort_busy", int'(bus1.busy), 0);
    chk_i("abort_state", int'(st1), 0);
    @(negedge clk);
    rst = 1'b0;
    run(2'b10, W'('h10), W'('hc), W'('h17), (W + 1)'('h5));

    // WIDTH=100, LIMB=32: padded top limb, carry must land in bit 100.
    @(negedge clk);
    bus2.mode  = 2'b00;
    bus2.in_a  = '1;
    bus2.in_b  = W2'(1);
    bus2.in_m  = '0;
    bus2.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus2.start = 1'b0;
    exp2 = '0;
    exp2[W2] = 1'b1;
    seen2 = 1'b0;
    n2 = cyc - c0;
    while (!seen2 && n2 <= NL2 + 8) begin
      if (bus2.done) begin
        seen2 = 1'b1;
        chk_i("w100_latency", n2, NL2 + 1);
        chk("w100_result", (W + 1)'(bus2.result), (W + 1)'(exp2));
      end else begin
        @(negedge clk);
        n2 = cyc - c0;
      end
    end
    if (!seen2) begin
      checks++;
      errors++;
      $error("FAIL w100_timeout observed=no_done expected=done_at_edge_%0d", NL2 + 1);
    end

    repeat (2) @(negedge clk);
    chk_i("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
